// File: rtl/sram_32_2048_stream_rd.sv
// Burst read-stream controller for the 32x2048 single-port SRAM: issues reads, absorbs them in a skid FIFO.
// Optional stall counter port enabled by defining SRAM_STREAM_RD_STALL_CNT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command; first read of a burst issues on accept
// S_ISSUE | issuing one read per cycle while FIFO credit is available
// S_DRAIN | all reads issued; waiting for pipe and FIFO to empty
module sram_32_2048_stream_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
`ifdef SRAM_STREAM_RD_STALL_CNT_EN
   ,output logic [15:0]           stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr, issue_addr;
    logic [ADDR_WIDTH:0]     remaining, rem_base;
    logic                    issue, issue_last, iss_last;
    logic [RD_LATENCY-1:0]   pipe_v, pipe_l;
    logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic [OW-1:0]           occ;
    logic                    credit_ok, push, pop;

    assign web0      = 1'b1;
    assign din0      = '0;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign push      = pipe_v[RD_LATENCY-1];
    assign pop       = out_valid && out_ready;

    // Occupancy counts every word already owed a FIFO slot: stored, registered at the macro, or in the pipe.
    always_comb begin
        occ = OW'(count) + OW'(!csb0);
        for (int i = 0; i < RD_LATENCY; i++) begin
            occ = occ + OW'(pipe_v[i]);
        end
    end

    assign credit_ok = (occ < OW'(FIFO_DEPTH));

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = cur_addr;
        rem_base   = remaining;
        case (state)
            S_IDLE: begin
                issue_addr = cmd_base;
                rem_base   = cmd_len;
                if (cmd_valid && (cmd_len != '0)) begin
                    issue      = 1'b1;
                    issue_last = (cmd_len == LEN_ONE);
                    state_nxt  = issue_last ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (remaining == LEN_ONE);
                    if (issue_last) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (csb0 && (pipe_v == '0) && (count == '0)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state     <= S_IDLE;
            csb0      <= 1'b1;
            addr0     <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            iss_last  <= 1'b0;
            pipe_v    <= '0;
            pipe_l    <= '0;
        end else begin
            state    <= state_nxt;
            iss_last <= issue_last;
            if (issue) begin
                csb0      <= 1'b0;
                addr0     <= issue_addr;
                cur_addr  <= issue_addr + ADDR_ONE;
                remaining <= rem_base - LEN_ONE;
            end else begin
                csb0 <= 1'b1;
            end
            // A tag enters the pipe at the edge where the macro samples the read.
            pipe_v[0] <= !csb0;
            pipe_l[0] <= iss_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_last <= '0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= pipe_l[RD_LATENCY-1];
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk0) begin
        if (push) fifo_data[wr_ptr] <= dout0;
    end

    assert property (@(posedge clk0) disable iff (!rstb0)
                     !(push && !pop && (count == CW'(FIFO_DEPTH))));

`ifdef SRAM_STREAM_RD_STALL_CNT_EN
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && cmd_valid) begin
            stall_cnt <= '0;
        end else if ((state == S_ISSUE) && !credit_ok && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
